// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared constants for the multi-cycle MIPS control unit.
//   - opcode constants for the supported instruction subset
//   - 4-bit controller state encoding
//   - ALUOp and PC-source select codes
//   - decode_next(): DECODE-state dispatch from opcode to the next state
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_FAULT
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Unsupported opcodes fall through to FAULT.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_RTYPE:     return S_EXEC_R;
            OP_LW, OP_SW: return S_ADDR;
            OP_BEQ:       return S_BRANCH;
            OP_ADDI:      return S_EXEC_I;
            OP_J:         return S_JUMP;
            default:      return S_FAULT;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on the memory port.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : force the count to 0 (has priority over enable)
//   enable       : increment the count this cycle
//   timeout      : count has reached LIMIT
module mem_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [7:0] LIMIT_C = 8'(LIMIT);

    logic [7:0] wait_cnt;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples values from before the clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout = (wait_cnt == LIMIT_C);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle control FSM for a small MIPS core.
//   clk, reset_n      : clock, asynchronous active-low reset
//   opcode            : Instruction[31:26] from the IR
//   zero              : ALU zero flag (used in BRANCH)
//   mem_ready         : RAM accepts/completes the current request
//   mem_req/mem_we    : RAM request strobe and write select
//   mem_addr_sel      : 0 = PC, 1 = ALU result as RAM address
//   ir_load, pc_write : IR and PC load strobes; pc_src selects the PC source
//   reg_dst, alu_src, alu_op, reg_write, mem_to_reg : datapath controls
//   fault             : sticky fault, cleared only by reset
//   instr_count       : retired-instruction counter (wraps)
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_load,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_dst,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        fault,
    output logic [31:0] instr_count
);

    state_t state, state_next;
    logic   waiting;
    logic   timeout;
    logic   retire;

    // Count only while stalled in a memory state; any other cycle clears the
    // counter, so each memory state is entered with a zero count.
    assign waiting = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR))
                     && !mem_ready;

    mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!waiting),
        .enable  (waiting),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output and state_next gets a default before the case, so no
    // path through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS4;
        reg_dst      = 1'b0;
        alu_src      = 1'b0;
        alu_op       = ALU_ADD;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        fault        = 1'b0;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    pc_write   = 1'b1;
                    pc_src     = PC_PLUS4;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: state_next = decode_next(opcode);
            S_EXEC_R: begin
                reg_dst    = 1'b1;
                alu_op     = ALU_FUNCT;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src    = 1'b1;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDR: begin
                alu_src    = 1'b1;
                state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD, S_MEM_WR: begin
                mem_req      = 1'b1;
                mem_we       = (state == S_MEM_WR);
                mem_addr_sel = 1'b1;
                alu_src      = 1'b1;
                if (mem_ready) begin
                    reg_write  = (state == S_MEM_RD);
                    mem_to_reg = (state == S_MEM_RD);
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_BRANCH: begin
                alu_op     = ALU_SUB;
                if (zero) begin
                    pc_write = 1'b1;
                    pc_src   = PC_BRANCH;
                end
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PC_JUMP;
                state_next = S_FETCH;
            end
            S_FAULT: fault = 1'b1;
            default: state_next = S_FAULT;
        endcase
    end

    // An instruction retires on any entry into FETCH except the one out of IDLE.
    assign retire = (state_next == S_FETCH) && (state != S_FETCH) && (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: self-checking bench for mips_multicycle_ctrl.
// The reference model expands each instruction into its expected per-cycle
// output vectors (given chosen memory wait lengths), which are then played
// against the DUT one cycle at a time.
// Output vector layout:
//   {mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_src[1:0],
//    reg_dst, alu_src, alu_op[1:0], reg_write, mem_to_reg, fault}
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    localparam int MEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        reset_n = 1'b1;
    logic [5:0]  opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_load, pc_write;
    logic [1:0]  pc_src, alu_op;
    logic        reg_dst, alu_src, reg_write, mem_to_reg, fault;
    logic [31:0] instr_count;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_load      (ir_load),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_dst      (reg_dst),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .fault        (fault),
        .instr_count  (instr_count)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic        z;
        logic [13:0] exp;
        logic [31:0] cnt;
    } cyc_t;

    cyc_t        q[$];
    logic [31:0] m_cnt;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [13:0] ov(input logic req, we, asel, irl, pcw,
                                       input logic [1:0] psrc,
                                       input logic rdst, asrc,
                                       input logic [1:0] aop,
                                       input logic rw, m2r, flt);
        return {req, we, asel, irl, pcw, psrc, rdst, asrc, aop, rw, m2r, flt};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [13:0] actual();
        return {mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_src,
                reg_dst, alu_src, alu_op, reg_write, mem_to_reg, fault};
    endfunction

    task automatic push(input logic [5:0] op, input logic rdy, z, input logic [13:0] exp);
        q.push_back('{op, rdy, z, exp, m_cnt});
    endtask

    // Fetch with fw not-ready cycles before the accepting cycle.
    task automatic build_fetch(input logic [5:0] op, input int fw);
        for (int i = 0; i < fw; i++) push(op, 1'b0, rb(), ov(1,0,0,0,0,2'b00,0,0,2'b00,0,0,0));
        push(op, 1'b1, rb(), ov(1,0,0,1,1,2'b00,0,0,2'b00,0,0,0));
    endtask

    // Whole instruction: fetch, decode, execute; mw = data-memory wait cycles.
    task automatic build_instr(input logic [5:0] op, input int fw, input int mw, input logic bz);
        logic is_sw;
        is_sw = (op == OP_SW);
        build_fetch(op, fw);
        push(op, rb(), rb(), '0);
        case (op)
            OP_RTYPE: begin
                push(op, rb(), rb(), ov(0,0,0,0,0,2'b00,1,0,2'b10,1,0,0));
                m_cnt++;
            end
            OP_ADDI: begin
                push(op, rb(), rb(), ov(0,0,0,0,0,2'b00,0,1,2'b00,1,0,0));
                m_cnt++;
            end
            OP_LW, OP_SW: begin
                push(op, rb(), rb(), ov(0,0,0,0,0,2'b00,0,1,2'b00,0,0,0));
                for (int i = 0; i < mw; i++)
                    push(op, 1'b0, rb(), ov(1,is_sw,1,0,0,2'b00,0,1,2'b00,0,0,0));
                push(op, 1'b1, rb(), ov(1,is_sw,1,0,0,2'b00,0,1,2'b00,!is_sw,!is_sw,0));
                m_cnt++;
            end
            OP_BEQ: begin
                push(op, rb(), bz, ov(0,0,0,0,bz,bz ? 2'b01 : 2'b00,0,0,2'b01,0,0,0));
                m_cnt++;
            end
            OP_J: begin
                push(op, rb(), rb(), ov(0,0,0,0,1,2'b10,0,0,2'b00,0,0,0));
                m_cnt++;
            end
            default: begin
                for (int i = 0; i < 100; i++) push(op, rb(), rb(), ov(0,0,0,0,0,2'b00,0,0,2'b00,0,0,1));
            end
        endcase
    endtask

    // Drives one cycle's inputs and returns the outputs sampled 1 ns later,
    // then advances to the next falling edge.
    task automatic run_cycle(input logic [5:0] op, input logic rdy, z,
                             output logic [13:0] act, output logic [31:0] cnt);
        opcode = op;
        mem_ready = rdy;
        zero = z;
        #1;
        act = actual();
        cnt = instr_count;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Holds reset across one rising edge, releases on a falling edge, and
    // seeds the model queue with the IDLE cycle that follows release.
    task automatic apply_reset();
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_cnt = '0;
        q.delete();
        push('0, rb(), rb(), '0);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (actual() !== 14'd0 || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_state outs=%b cnt=%0d expected outs=%b cnt=0", actual(), instr_count, 14'd0);
        end
    endtask

    task automatic test_rtype();
        logic [13:0] act;
        logic [31:0] cnt;
        apply_reset();
        build_instr(OP_RTYPE, 2, 0, 1'b0);
        push(OP_RTYPE, 1'b0, 1'b0, ov(1,0,0,0,0,2'b00,0,0,2'b00,0,0,0));
        foreach (q[i]) begin
            run_cycle(q[i].op, q[i].rdy, q[i].z, act, cnt);
            checks++;
            if (act !== q[i].exp || cnt !== q[i].cnt) begin
                failures++;
                $display("FAIL rtype cyc=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, act, cnt, q[i].exp, q[i].cnt);
            end
        end
    endtask

    task automatic test_lw_sw();
        logic [13:0] act;
        logic [31:0] cnt;
        apply_reset();
        build_instr(OP_LW, 0, 0, 1'b0);
        build_instr(OP_SW, 0, 3, 1'b0);
        build_instr(OP_LW, 1, 2, 1'b0);
        push(OP_LW, 1'b0, 1'b0, ov(1,0,0,0,0,2'b00,0,0,2'b00,0,0,0));
        foreach (q[i]) begin
            run_cycle(q[i].op, q[i].rdy, q[i].z, act, cnt);
            checks++;
            if (act !== q[i].exp || cnt !== q[i].cnt) begin
                failures++;
                $display("FAIL lw_sw cyc=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, act, cnt, q[i].exp, q[i].cnt);
            end
        end
    endtask

    task automatic test_beq();
        logic [13:0] act;
        logic [31:0] cnt;
        apply_reset();
        build_instr(OP_BEQ, 0, 0, 1'b1);
        build_instr(OP_BEQ, 1, 0, 1'b0);
        build_instr(OP_J, 0, 0, 1'b0);
        push(OP_J, 1'b0, 1'b0, ov(1,0,0,0,0,2'b00,0,0,2'b00,0,0,0));
        foreach (q[i]) begin
            run_cycle(q[i].op, q[i].rdy, q[i].z, act, cnt);
            checks++;
            if (act !== q[i].exp || cnt !== q[i].cnt) begin
                failures++;
                $display("FAIL beq_j cyc=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, act, cnt, q[i].exp, q[i].cnt);
            end
        end
    endtask

    task automatic test_illegal();
        logic [13:0] act;
        logic [31:0] cnt;
        apply_reset();
        build_instr(OP_ADDI, 0, 0, 1'b0);
        build_instr(6'b111111, 0, 0, 1'b0);
        foreach (q[i]) begin
            run_cycle(q[i].op, q[i].rdy, q[i].z, act, cnt);
            checks++;
            if (act !== q[i].exp || cnt !== q[i].cnt) begin
                failures++;
                $display("FAIL illegal cyc=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, act, cnt, q[i].exp, q[i].cnt);
            end
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL fault_clear fault=%b cnt=%0d expected fault=0 cnt=0", fault, instr_count);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [13:0] act;
        logic [31:0] cnt;
        apply_reset();
        for (int i = 0; i <= MEM_TIMEOUT; i++) push(OP_RTYPE, 1'b0, rb(), ov(1,0,0,0,0,2'b00,0,0,2'b00,0,0,0));
        for (int i = 0; i < 5; i++) push(OP_RTYPE, rb(), rb(), ov(0,0,0,0,0,2'b00,0,0,2'b00,0,0,1));
        foreach (q[i]) begin
            run_cycle(q[i].op, q[i].rdy, q[i].z, act, cnt);
            checks++;
            if (act !== q[i].exp || cnt !== q[i].cnt) begin
                failures++;
                $display("FAIL timeout cyc=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, act, cnt, q[i].exp, q[i].cnt);
            end
        end
        // Ready on the last allowed cycle wins over the timeout, in FETCH and MEM_RD.
        apply_reset();
        build_instr(OP_LW, MEM_TIMEOUT, MEM_TIMEOUT, 1'b0);
        push(OP_LW, 1'b0, 1'b0, ov(1,0,0,0,0,2'b00,0,0,2'b00,0,0,0));
        foreach (q[i]) begin
            run_cycle(q[i].op, q[i].rdy, q[i].z, act, cnt);
            checks++;
            if (act !== q[i].exp || cnt !== q[i].cnt) begin
                failures++;
                $display("FAIL timeout_edge cyc=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, act, cnt, q[i].exp, q[i].cnt);
            end
        end
    endtask

    task automatic test_reset_mid_sw();
        logic [13:0] act;
        logic [31:0] cnt;
        apply_reset();
        build_instr(OP_RTYPE, 0, 0, 1'b0);
        build_fetch(OP_SW, 0);
        push(OP_SW, rb(), rb(), '0);
        push(OP_SW, rb(), rb(), ov(0,0,0,0,0,2'b00,0,1,2'b00,0,0,0));
        push(OP_SW, 1'b0, rb(), ov(1,1,1,0,0,2'b00,0,1,2'b00,0,0,0));
        push(OP_SW, 1'b0, rb(), ov(1,1,1,0,0,2'b00,0,1,2'b00,0,0,0));
        foreach (q[i]) begin
            run_cycle(q[i].op, q[i].rdy, q[i].z, act, cnt);
            checks++;
            if (act !== q[i].exp || cnt !== q[i].cnt) begin
                failures++;
                $display("FAIL mid_sw cyc=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, act, cnt, q[i].exp, q[i].cnt);
            end
        end
        // Still waiting in MEM_WR; stop the clock and reset.
        mem_ready = 1'b0;
        #1;
        clk_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (actual() !== 14'd0 || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL async_reset outs=%b cnt=%0d expected outs=%b cnt=0", actual(), instr_count, 14'd0);
        end
        #20;
        reset_n = 1'b1;
        clk_en = 1'b1;
        #1;
        checks++;
        if (actual() !== 14'd0 || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_idle outs=%b cnt=%0d expected outs=%b cnt=0", actual(), instr_count, 14'd0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (actual() !== ov(1,0,0,0,0,2'b00,0,0,2'b00,0,0,0) || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_fetch outs=%b cnt=%0d expected outs=%b cnt=0",
                     actual(), instr_count, ov(1,0,0,0,0,2'b00,0,0,2'b00,0,0,0));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [13:0] act;
        logic [31:0] cnt;
        logic [5:0]  legal [6];
        legal = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        apply_reset();
        for (int n = 0; n < 40; n++)
            build_instr(legal[$urandom_range(0, 5)], int'($urandom_range(0, 4)),
                        int'($urandom_range(0, 4)), rb());
        push(OP_RTYPE, 1'b0, 1'b0, ov(1,0,0,0,0,2'b00,0,0,2'b00,0,0,0));
        foreach (q[i]) begin
            run_cycle(q[i].op, q[i].rdy, q[i].z, act, cnt);
            checks++;
            if (act !== q[i].exp || cnt !== q[i].cnt) begin
                failures++;
                $display("FAIL random cyc=%0d op=%b outs=%b cnt=%0d expected outs=%b cnt=%0d",
                         i, q[i].op, act, cnt, q[i].exp, q[i].cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_sw();
        test_beq();
        test_illegal();
        test_timeout();
        test_reset_mid_sw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
